// File: rtl/regfile_dump_reader.sv
// Purpose: walks a register-index range on the registerfile read port and streams each word out on a valid/ready link.
// Latency: first beat is valid READ_LATENCY+1 edges after start; with dumpReady held high, one beat every READ_LATENCY+1 cycles.
// Backpressure: dumpValid/dumpData/dumpAddr stay frozen in SEND until dumpReady; the next read is not issued until that handshake.
module regfile_dump_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] firstAddr,
    input  logic [ADDR_WIDTH-1:0] lastAddr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] regS,
    output logic                  registerFileWP,
    input  logic [DATA_WIDTH-1:0] regsOutA,
    output logic [DATA_WIDTH-1:0] dumpData,
    output logic [ADDR_WIDTH-1:0] dumpAddr,
    output logic                  dumpValid,
    input  logic                  dumpReady,
    output logic                  busy,
    output logic                  done,
    output logic                  rangeError
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // Edge count at which the read data is valid; the counter starts at 2
    // because the ADDR cycle already accounts for the first edge.
    localparam logic [1:0] LAT_CODE = 2'(READ_LATENCY);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cursor;
    logic [ADDR_WIDTH-1:0]   r_last;
    logic [ADDR_WIDTH-1:0]   r_regs;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_vld;
    logic                    r_done;
    logic                    r_rerr;
    logic                    r_abort;
    logic [1:0]              r_lat_cnt;

    logic                    w_handshake;
    logic                    w_abort_now;
    logic                    w_last_beat;
    logic [ADDR_WIDTH-1:0]   w_next;

    // An abort seen this cycle counts the same as one latched earlier.
    assign w_handshake = r_vld & dumpReady;
    assign w_abort_now = r_abort | abort;
    // Compare before incrementing so a range ending at the top index never wraps.
    assign w_last_beat = (r_cursor == r_last);
    assign w_next      = r_cursor + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Single sequencer: address issue, read-latency wait, beat hand-off, done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cursor  <= '0;
            r_last    <= '0;
            r_regs    <= '0;
            r_data    <= '0;
            r_addr    <= '0;
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
            r_rerr    <= 1'b0;
            r_abort   <= 1'b0;
            r_lat_cnt <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // abort is ignored here, so a same-cycle start always wins
                    if (start) begin
                        r_last <= lastAddr;
                        if (firstAddr > lastAddr) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_rerr  <= 1'b1;
                        end else begin
                            r_regs   <= firstAddr;
                            r_cursor <= firstAddr;
                            r_state  <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    r_abort <= r_abort | abort;
                    if (w_abort_now) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else if (READ_LATENCY <= 1) begin
                        r_data  <= regsOutA;
                        r_addr  <= r_cursor;
                        r_vld   <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_lat_cnt <= 2'd2;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_abort <= r_abort | abort;
                    if (w_abort_now) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else if (r_lat_cnt >= LAT_CODE) begin
                        r_data  <= regsOutA;
                        r_addr  <= r_cursor;
                        r_vld   <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end

                S_SEND: begin
                    // Abort here is only latched; the beat on the link still completes.
                    r_abort <= r_abort | abort;
                    if (w_handshake) begin
                        r_vld <= 1'b0;
                        if (w_last_beat || w_abort_now) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_cursor <= w_next;
                            r_regs   <= w_next;
                            r_state  <= S_ADDR;
                        end
                    end
                end

                S_FIN: begin
                    r_done  <= 1'b0;
                    r_rerr  <= 1'b0;
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The block only reads, so write-protect is held permanently.
    assign registerFileWP = 1'b1;
    assign regS           = r_regs;
    assign dumpData       = r_data;
    assign dumpAddr       = r_addr;
    assign dumpValid      = r_vld;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign rangeError     = r_rerr;

endmodule
